rvr32_mem_arb: RTL and testbench

//   Two-master arbiter sharing the single native memory port (valid/ready, word addr, wstrb)

---
 rtl/rvr32_mem_arb.sv | 135 +++++++++++++
 tb/tb_rvr32_mem_arb.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/rvr32_mem_arb.sv
// rvr32_mem_arb: IFU/LSU arbiter onto a registered native memory port with bus timeout (RVR32_MEM_ARB_RR_EN selects round-robin)
module rvr32_mem_arb #(
  parameter int TIMEOUT = 256,
  parameter int TO_W    = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ifu_valid,
  input  logic [31:0] ifu_addr,
  output logic        ifu_ready,
  output logic [31:0] ifu_rdata,
  output logic        ifu_err,
  input  logic        lsu_valid,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wstrb,
  output logic        lsu_ready,
  output logic [31:0] lsu_rdata,
  output logic        lsu_err,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        grant,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} state_e;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  state_e            state_q, state_d;
  logic              mem_valid_q, mem_valid_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_wstrb_q, mem_wstrb_d;
  logic              grant_q, grant_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic              pick_lsu;
  logic              any_req;
  logic              to_hit;
  assign any_req = ifu_valid | lsu_valid;
  assign to_hit  = (TIMEOUT != 0) && (cnt_q == TO_LAST);
`ifdef RVR32_MEM_ARB_RR_EN
  logic rr_q, rr_d;
  // rr_q remembers the last winner so a contested grant goes to the other master
  assign pick_lsu = lsu_valid & (~ifu_valid | ~rr_q);
  assign rr_d     = (state_q == IDLE && any_req) ? pick_lsu : rr_q;
  // round-robin pointer register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rr_q <= 1'b0;
    else        rr_q <= rr_d;
`else
  assign pick_lsu = lsu_valid;
`endif
  // state and bus-side registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      grant_q     <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      grant_q     <= grant_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end
  // next state: grant in IDLE, complete or time out in BUS, single response cycle in RESP
  always_comb begin
    state_d     = state_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    grant_d     = grant_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: if (any_req) begin
        state_d     = BUS;
        mem_valid_d = 1'b1;
        grant_d     = pick_lsu;
        mem_addr_d  = pick_lsu ? lsu_addr : ifu_addr;
        mem_wdata_d = pick_lsu ? lsu_wdata : 32'd0;
        mem_wstrb_d = pick_lsu ? lsu_wstrb : 4'd0;
        cnt_d       = '0;
      end
      BUS: if (mem_valid_q & mem_ready) begin
        state_d     = RESP;
        mem_valid_d = 1'b0;
        rdata_d     = mem_rdata;
        err_d       = 1'b0;
      end else if (to_hit) begin
        state_d     = RESP;
        mem_valid_d = 1'b0;
        rdata_d     = 32'd0;
        err_d       = 1'b1;
      end else begin
        cnt_d = cnt_q + TO_W'(1);
      end
      RESP: begin
        state_d = IDLE;
        rdata_d = 32'd0;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  assign ifu_ready = (state_q == RESP) & ~grant_q;
  assign lsu_ready = (state_q == RESP) & grant_q;
  assign ifu_rdata = ifu_ready ? rdata_q : 32'd0;
  assign lsu_rdata = lsu_ready ? rdata_q : 32'd0;
  assign ifu_err   = ifu_ready & err_q;
  assign lsu_err   = lsu_ready & err_q;
  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign grant     = grant_q;
  assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_rvr32_mem_arb.sv
// tb_rvr32_mem_arb: directed checks of grant, latency, timeout and reset behaviour
module tb_rvr32_mem_arb;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ifu_valid = 1'b0;
  logic [31:0] ifu_addr = '0;
  logic        ifu_ready;
  logic [31:0] ifu_rdata;
  logic        ifu_err;
  logic        lsu_valid = 1'b0;
  logic [31:0] lsu_addr = '0;
  logic [31:0] lsu_wdata = '0;
  logic [3:0]  lsu_wstrb = '0;
  logic        lsu_ready;
  logic [31:0] lsu_rdata;
  logic        lsu_err;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        grant;
  logic        busy;
  int          checks = 0;
  int          errors = 0;
  always #5 clk = ~clk;
  rvr32_mem_arb #(.TIMEOUT(8), .TO_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_valid(ifu_valid), .ifu_addr(ifu_addr), .ifu_ready(ifu_ready), .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
    .lsu_valid(lsu_valid), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
    .lsu_ready(lsu_ready), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .grant(grant), .busy(busy)
  );
  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    checks++; if ({mem_valid, busy, grant, ifu_ready, lsu_ready} !== 5'b0) begin errors++; $display("FAIL reset_ctrl got %b exp 00000", {mem_valid, busy, grant, ifu_ready, lsu_ready}); end
    checks++; if ({mem_addr, mem_wdata, mem_wstrb} !== 68'd0) begin errors++; $display("FAIL reset_bus got %h exp 0", {mem_addr, mem_wdata, mem_wstrb}); end
    rst_n = 1'b1;
  endtask
  task automatic test_ifu_only;
    mem_ready = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    ifu_valid = 1'b1;
    ifu_addr  = 32'h100;
    @(negedge clk);
    checks++; if ({mem_valid, busy, grant, ifu_ready} !== 4'b1100) begin errors++; $display("FAIL ifu_c1_ctrl got %b exp 1100", {mem_valid, busy, grant, ifu_ready}); end
    checks++; if ({mem_addr, mem_wstrb} !== {32'h100, 4'd0}) begin errors++; $display("FAIL ifu_c1_bus got %h exp %h", {mem_addr, mem_wstrb}, {32'h100, 4'd0}); end
    @(negedge clk);
    checks++; if ({ifu_ready, lsu_ready, ifu_err, mem_valid} !== 4'b1000) begin errors++; $display("FAIL ifu_c2_ready got %b exp 1000", {ifu_ready, lsu_ready, ifu_err, mem_valid}); end
    checks++; if (ifu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL ifu_c2_rdata got %h exp deadbeef", ifu_rdata); end
    ifu_valid = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    checks++; if ({ifu_ready, busy, ifu_rdata} !== 34'd0) begin errors++; $display("FAIL ifu_c3_idle got %h exp 0", {ifu_ready, busy, ifu_rdata}); end
  endtask
  task automatic test_lsu_store;
    mem_rdata = 32'h55AA55AA;
    lsu_valid = 1'b1;
    lsu_addr  = 32'h204;
    lsu_wdata = 32'h12121212;
    lsu_wstrb = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if ({mem_valid, grant, mem_addr, mem_wdata, mem_wstrb} !== {2'b11, 32'h204, 32'h12121212, 4'b0100}) begin errors++; $display("FAIL store_hold%0d got %h exp %h", i, {mem_valid, grant, mem_addr, mem_wdata, mem_wstrb}, {2'b11, 32'h204, 32'h12121212, 4'b0100}); end
      checks++; if ({ifu_ready, lsu_ready} !== 2'b00) begin errors++; $display("FAIL store_noready%0d got %b exp 00", i, {ifu_ready, lsu_ready}); end
      lsu_addr  = 32'hFFFF_FFF0;
      lsu_wdata = 32'hA5A5A5A5;
      lsu_wstrb = 4'b1111;
      mem_ready = (i == 3);
    end
    @(negedge clk);
    checks++; if ({lsu_ready, ifu_ready, lsu_err, mem_valid} !== 4'b1000) begin errors++; $display("FAIL store_resp got %b exp 1000", {lsu_ready, ifu_ready, lsu_err, mem_valid}); end
    checks++; if (lsu_rdata !== 32'h55AA55AA) begin errors++; $display("FAIL store_rdata got %h exp 55aa55aa", lsu_rdata); end
    lsu_valid = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    checks++; if ({lsu_ready, busy} !== 2'b00) begin errors++; $display("FAIL store_after got %b exp 00", {lsu_ready, busy}); end
  endtask
  task automatic test_arbitration;
    logic [3:0] ord;
    int n, ic, lc;
    logic [3:0] exp_ord;
`ifdef RVR32_MEM_ARB_RR_EN
    exp_ord = 4'b0101;
`else
    exp_ord = 4'b0011;
`endif
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ord = '0; n = 0; ic = 0; lc = 0;
    mem_ready = 1'b1;
    mem_rdata = 32'h0F0F0F0F;
    ifu_valid = 1'b1; ifu_addr = 32'h40;
    lsu_valid = 1'b1; lsu_addr = 32'h80; lsu_wstrb = 4'b0000;
    for (int k = 0; k < 40 && n < 4; k++) begin
      @(negedge clk);
      if (ifu_ready) begin ord[n] = 1'b0; n++; ic++; if (ic == 2) ifu_valid = 1'b0; end
      if (lsu_ready) begin ord[n] = 1'b1; n++; lc++; if (lc == 2) lsu_valid = 1'b0; end
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL arb_count got %0d exp 4", n); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (ord[i] !== exp_ord[i]) begin errors++; $display("FAIL arb_order%0d got %b exp %b", i, ord[i], exp_ord[i]); end
    end
    ifu_valid = 1'b0;
    lsu_valid = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_timeout;
    int n;
    logic seen;
    n = 0; seen = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = 32'hCAFEF00D;
    lsu_valid = 1'b1; lsu_addr = 32'h600; lsu_wstrb = 4'b0000;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      if (lsu_ready) seen = 1'b1;
      else if (mem_valid) n++;
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL to_ready got %b exp 1", seen); end
    checks++; if (n !== 8) begin errors++; $display("FAIL to_cycles got %0d exp 8", n); end
    checks++; if ({lsu_err, lsu_rdata} !== {1'b1, 32'd0}) begin errors++; $display("FAIL to_err_rdata got %h exp %h", {lsu_err, lsu_rdata}, {1'b1, 32'd0}); end
    lsu_valid = 1'b0;
    ifu_valid = 1'b1; ifu_addr = 32'h300;
    mem_ready = 1'b1; mem_rdata = 32'h0BADF00D;
    seen = 1'b0;
    for (int k = 0; k < 6 && !seen; k++) begin
      @(negedge clk);
      if (ifu_ready) seen = 1'b1;
    end
    checks++; if ({seen, ifu_err, ifu_rdata} !== {2'b10, 32'h0BADF00D}) begin errors++; $display("FAIL to_next got %h exp %h", {seen, ifu_err, ifu_rdata}, {2'b10, 32'h0BADF00D}); end
    ifu_valid = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_coincide;
    int n;
    n = 0;
    mem_ready = 1'b0;
    mem_rdata = 32'h87654321;
    lsu_valid = 1'b1; lsu_addr = 32'h700;
    for (int k = 0; k < 20 && n < 8; k++) begin
      @(negedge clk);
      if (mem_valid) n++;
    end
    checks++; if (n !== 8) begin errors++; $display("FAIL co_cycles got %0d exp 8", n); end
    mem_ready = 1'b1;
    @(negedge clk);
    checks++; if ({lsu_ready, lsu_err, lsu_rdata} !== {2'b10, 32'h87654321}) begin errors++; $display("FAIL co_resp got %h exp %h", {lsu_ready, lsu_err, lsu_rdata}, {2'b10, 32'h87654321}); end
    lsu_valid = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_reset_mid;
    lsu_valid = 1'b1; lsu_addr = 32'h400; lsu_wstrb = 4'b0000;
    @(negedge clk);
    checks++; if ({mem_valid, busy, grant} !== 3'b111) begin errors++; $display("FAIL rm_bus got %b exp 111", {mem_valid, busy, grant}); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({mem_valid, busy, grant, mem_addr} !== 35'd0) begin errors++; $display("FAIL rm_async got %h exp 0", {mem_valid, busy, grant, mem_addr}); end
    lsu_valid = 1'b0;
    ifu_valid = 1'b1; ifu_addr = 32'h500;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({mem_valid, grant, mem_addr} !== {2'b10, 32'h500}) begin errors++; $display("FAIL rm_restart got %h exp %h", {mem_valid, grant, mem_addr}, {2'b10, 32'h500}); end
    mem_ready = 1'b1; mem_rdata = 32'h13572468;
    @(negedge clk);
    checks++; if ({ifu_ready, ifu_err, ifu_rdata} !== {2'b10, 32'h13572468}) begin errors++; $display("FAIL rm_resp got %h exp %h", {ifu_ready, ifu_err, ifu_rdata}, {2'b10, 32'h13572468}); end
    ifu_valid = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
  endtask
  initial begin
    test_reset();
    test_ifu_only();
    test_lsu_store();
    test_arbitration();
    test_timeout();
    test_coincide();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
